// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences core load/store requests onto a byte-wide synchronous
// data memory, one byte per cycle, little-endian, with sign/zero extension of loads.
module dmem_access_ctrl #(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              we_reg, we_next;
    logic [1:0]        size_reg, size_next;
    logic              signed_reg, signed_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [2:0]        idx_reg, idx_next;
    logic [31:0]       asm_reg, asm_next;
    logic              err_reg, err_next;

    logic [2:0]        req_nbytes;
    logic [ADDR_W:0]   req_last;
    logic              req_bad;
    logic [2:0]        last_idx;
    logic [1:0]        cap_idx;
    logic [31:0]       asm_cap;
    logic [7:0]        wlane [4];
    logic [31:0]       ext_data;
    logic              unused_rdata_hi;

    assign unused_rdata_hi = ^mem_rdata[31:8];

    always_comb begin
        case (req_size)
            2'd0:    req_nbytes = 3'd1;
            2'd1:    req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
    end

    // One extra address bit so a range check near the top of the address space cannot wrap.
    assign req_last = {1'b0, req_addr} + (ADDR_W+1)'(req_nbytes) - (ADDR_W+1)'(1);
    assign req_bad  = (req_size == 2'd3) || (req_last >= (ADDR_W+1)'(MEM_BYTES));

    always_comb begin
        case (size_reg)
            2'd0:    last_idx = 3'd0;
            2'd1:    last_idx = 3'd1;
            default: last_idx = 3'd3;
        endcase
    end

    // Memory returns the byte for the previous cycle's address, hence lane idx-1.
    assign cap_idx = idx_reg[1:0] - 2'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wlane[gi]             = wdata_reg[8*gi +: 8];
            assign asm_cap[8*gi +: 8]    = (cap_idx == 2'(gi)) ? mem_rdata[7:0]
                                                               : asm_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (size_reg)
            2'd0:    ext_data = {{24{signed_reg & asm_reg[7]}}, asm_reg[7:0]};
            2'd1:    ext_data = {{16{signed_reg & asm_reg[15]}}, asm_reg[15:0]};
            default: ext_data = asm_reg;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        we_next     = we_reg;
        size_next   = size_reg;
        signed_next = signed_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        idx_next    = idx_reg;
        asm_next    = asm_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    we_next     = req_we;
                    size_next   = req_size;
                    signed_next = req_signed;
                    addr_next   = req_addr;
                    wdata_next  = req_wdata;
                    idx_next    = 3'd0;
                    asm_next    = 32'd0;
                    err_next    = req_bad;
                    state_next  = req_bad ? RESP : XFER;
                end
            end
            XFER: begin
                idx_next = idx_reg + 3'd1;
                if (!we_reg && (idx_reg != 3'd0)) begin
                    asm_next = asm_cap;
                end
                if (idx_reg == last_idx) begin
                    state_next = we_reg ? RESP : CAPT;
                end
            end
            CAPT: begin
                asm_next   = asm_cap;
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            size_reg   <= 2'd0;
            signed_reg <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= 32'd0;
            idx_reg    <= 3'd0;
            asm_reg    <= 32'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            we_reg     <= we_next;
            size_reg   <= size_next;
            signed_reg <= signed_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            idx_reg    <= idx_next;
            asm_reg    <= asm_next;
            err_reg    <= err_next;
        end
    end

    // Outputs decode straight from the state register so reset silences the memory port at once.
    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_err   = (state_reg == RESP) && err_reg;
    assign resp_rdata = ((state_reg == RESP) && !we_reg && !err_reg) ? ext_data : 32'd0;
    assign mem_we     = (state_reg == XFER) && we_reg;
    assign mem_addr   = (state_reg == XFER) ? addr_reg + ADDR_W'(idx_reg) : '0;
    assign mem_wdata  = (state_reg == XFER) ? {24'd0, wlane[idx_reg[1:0]]} : 32'd0;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences processor load/store requests onto the byte-wide data memory (4096 x 8, synchronous read, 1-cycle read latency, 1 byte per cycle).
- Splits word and halfword accesses into consecutive little-endian byte accesses, assembles read bytes, and applies sign or zero extension.
- Sits between the core's load/store unit and the data memory. Both sides use valid/ready handshakes.

Parameters:
- MEM_BYTES, 4096, size of the byte memory. An access touching any byte at or above MEM_BYTES is an error.
- ADDR_W, 32, width of request and memory addresses.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  ADDR_W  byte address of the lowest byte. Misalignment is allowed.
- req_wdata  input  32  store data, little-endian; only the low 8*n bits are used.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  illegal size or out-of-range access.
- mem_we  output  1  byte write enable to memory.
- mem_addr  output  ADDR_W  byte address to memory.
- mem_wdata  output  32  [7:0] = byte being written; [31:8] = 0.
- mem_rdata  input  32  [7:0] = byte read for the address presented in the previous cycle.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - req_ready = 1 once in IDLE.
  - Reset mid-transfer abandons the transfer; mem_we drops immediately and no response is produced.
- Byte count n: size 0 gives n = 1, size 1 gives n = 2, size 2 gives n = 4.
- States: IDLE, XFER, CAPT, RESP.
- IDLE, on req_valid & req_ready: latch we, size, signed, addr, wdata; clear the byte index idx and the assembly register.
  - If size = 3, or addr + n - 1 >= MEM_BYTES (computed without 32-bit overflow), go to RESP with resp_err = 1. No memory access occurs.
  - Otherwise go to XFER.
- XFER, one byte per cycle:
  - Outputs: mem_addr = base + idx, mem_we = latched we, mem_wdata[7:0] = wdata[8*idx+7 : 8*idx].
  - Loads: in each XFER cycle with idx > 0, capture mem_rdata[7:0] into assembly byte idx-1.
  - idx increments each cycle.
  - After byte n-1 is issued: stores go to RESP; loads go to CAPT.
- CAPT: capture the final byte n-1; mem_we = 0; go to RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are stable while resp_valid is high.
  - Move to IDLE on resp_ready.
  - resp_ready may already be high on the first RESP cycle; there are no back-to-back shortcuts.
- mem_we is 0 in every state except XFER of a store.
- Extension of load data:
  - Byte: bit 7 replicated into [31:8] if signed, else zeros.
  - Half: bit 15 replicated into [31:16] if signed, else zeros.
  - Word: unmodified.
- Latency, with acceptance edge T:
  - Store: resp_valid first high in cycle T+n+1.
  - Load: resp_valid first high in cycle T+n+2.
  - Error: resp_valid first high in cycle T+1.
- Throughput: one request in flight; req_ready = 0 from XFER through RESP.
- Inputs req_* are ignored outside IDLE; the latched copy is used throughout the transfer.

Test Plan:
- Word store then load: store addr 0x010, wdata 0xA1B2C3D4. Required: bytes D4, C3, B2, A1 written to 0x010..0x013 on consecutive cycles; resp_valid at T+5. Load word from 0x010 returns 0xA1B2C3D4 at T+6, resp_err = 0.
- Signed vs unsigned byte load of 0x80 at 0x020: signed returns 0xFFFFFF80; unsigned returns 0x00000080; each resp_valid at T+3.
- Misaligned half load at 0x011 after the first test: returns 0x0000B2C3 (unsigned) or 0xFFFFB2C3 (signed). mem_addr sequence is 0x011, 0x012.
- Boundary: word load at 0xFFC succeeds. Word load at 0xFFD and size = 3 at any address each return resp_err = 1 at T+1, with no mem_we pulse and no mem_addr change.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP. Required: resp_valid and resp_rdata stable, req_ready = 0, a new req_valid is not accepted. Release, then IDLE the next cycle.
- Reset mid-store: assert rst_n = 0 during XFER of a word store after 2 bytes. Required: mem_we = 0 immediately, only 2 bytes modified, no resp_valid, and a new request is accepted after rst_n deasserts.
